apb_master: RTL
===============

Name: apb_master

Overview:
- APB3 initiator; the requester side of the APB slaves on the peripheral bus (LED, GPIO, etc.).
- Accepts single read/write commands on a valid/ready port and decodes the address to one of NSLV PSEL lines.
- Runs the SETUP/ACCESS sequence, honours PREADY wait states and PSLVERR, and returns one response per command.
- A wait-state timeout stops a hung slave from stalling the bus.

Parameters:
- NSLV, 4, number of APB slaves (PSEL lines), 1..16.
- DEC_LSB, 12, LSB of the slave-index field in cmd_addr; field width SELW = clog2(NSLV), minimum 1.
- TIMEOUT, 256, ACCESS cycles with PREADY low before abort; 0 disables the timeout.

Ports:
- PCLK  in  1  bus clock; the single clock.
- PRESET  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  32  byte address.
- cmd_wdata  in  32  write data.
- rsp_valid  out  1  one-cycle response pulse; no backpressure.
- rsp_rdata  out  32  read data; 0 for writes and errors.
- rsp_err  out  1  slave error, timeout or decode error.
- PSEL  out  NSLV  one-hot slave select.
- PENABLE  out  1  ACCESS phase.
- PWRITE  out  1  transfer direction.
- PADDR  out  32  transfer address.
- PWDATA  out  32  write data.
- PRDATA  in  NSLV*32  per-slave read data; slave i at bits [32i+31:32i].
- PREADY  in  NSLV  per-slave ready.
- PSLVERR  in  NSLV  per-slave error.

Behaviour:
- Reset: state IDLE, wait counter 0, every output 0.
  - cmd_ready also reads 0 while PRESET is asserted; it rises in the first cycle after release.
  - Reset asserted mid-transfer drops the transfer immediately: PSEL and PENABLE fall asynchronously and no rsp_valid is ever produced for it.
- States: IDLE, SETUP, ACCESS, DECERR.
- Index decode: idx = cmd_addr[DEC_LSB +: SELW].
- IDLE:
  - cmd_ready = 1; a handshake is cmd_valid & cmd_ready.
  - On handshake, cmd_write, cmd_addr and cmd_wdata are registered onto PWRITE, PADDR and PWDATA, and idx is registered.
  - idx < NSLV: go to SETUP.
  - idx >= NSLV: go to DECERR; no PSEL is ever raised.
- SETUP (one cycle): PSEL[idx] = 1, PENABLE = 0. Always goes to ACCESS.
- ACCESS:
  - PSEL[idx] = 1, PENABLE = 1.
  - Sample PREADY[idx] and PSLVERR[idx] at each rising edge.
  - If PREADY[idx] = 1:
    - Next cycle: rsp_valid = 1 and rsp_err = PSLVERR[idx].
    - rsp_rdata = PRDATA[idx] if it is a read with no error, else 0.
    - PSEL and PENABLE drop; state goes to IDLE.
  - Else the wait counter increments. When TIMEOUT != 0 and the counter reaches TIMEOUT, abort: next cycle rsp_valid = 1, rsp_err = 1, rsp_rdata = 0, PSEL and PENABLE drop, state goes to IDLE.
  - The counter clears on entry to SETUP.
- DECERR (one cycle): rsp_valid = 1, rsp_err = 1, rsp_rdata = 0; then IDLE.
- Stability:
  - PADDR, PWRITE and PWDATA stay constant from SETUP through the last ACCESS cycle.
  - In IDLE they hold their last values and are not cleared.
- Latency:
  - Handshake in cycle 0 gives SETUP in cycle 1 and ACCESS in cycle 2.
  - Zero-wait completion gives rsp_valid in cycle 3, with cmd_ready high again in cycle 3.
  - Each wait state adds 1 cycle.
  - The minimum command-to-command period is 3 cycles; there is no back-to-back SETUP.
- A command presented while cmd_ready = 0 is not consumed; the requester holds it.
- rsp_valid stays low at all times other than the single completion cycle.
- The timeout counter is wide enough for TIMEOUT and saturates; it cannot wrap.

Decomposition:
- Package apb_pkg holds:
  - the state encoding (IDLE, SETUP, ACCESS, DECERR);
  - the localparams SELW and CNTW;
  - a function for the one-hot PSEL encode.
- One sub-module, apb_rsp_mux: combinational NSLV:1 mux of PRDATA, PREADY and PSLVERR selected by the registered idx. It is reused by the future AHB-to-APB bridge.

Test Plan:
- Zero-wait write, PREADY tied high: cmd addr 0x0000_0004, wdata 0xA5 -> PSEL = 0001 in cycles 1-2, PENABLE in cycle 2 only, PWDATA = 0xA5, rsp_valid in cycle 3 with err = 0.
- Read from slave 2 (addr 0x0000_2000), PREADY low for 3 ACCESS cycles, PRDATA = 0x1234 -> PENABLE high for 4 cycles with PADDR stable, rsp_valid in cycle 6 with rsp_rdata = 0x1234.
- Write with PSLVERR = 1 at completion -> rsp_err = 1, rsp_rdata = 0, FSM back in IDLE, next command accepted.
- TIMEOUT = 8 with PREADY held low -> exactly 8 ACCESS cycles, then rsp_valid with err = 1 and PSEL = 0.
- NSLV = 3, addr 0x0000_3000 -> no PSEL raised, rsp_valid with err = 1 in cycle 2.
- PRESET pulsed in the second ACCESS cycle -> PSEL and PENABLE go to 0 asynchronously, no rsp_valid, cmd_ready = 1 in the first cycle after release.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared definitions for the APB3 initiator: FSM states, field widths and the PSEL encoder.
package apb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StDecerr
  } apb_state_e;

  function automatic int sel_width(input int unsigned nslv);
    return ($clog2(nslv) < 1) ? 1 : $clog2(nslv);
  endfunction

  function automatic int cnt_width(input int unsigned timeout);
    return ($clog2(timeout + 1) < 1) ? 1 : $clog2(timeout + 1);
  endfunction

  // Widths for the default configuration (4 slaves, 256-cycle timeout).
  localparam int unsigned SELW = sel_width(4);
  localparam int unsigned CNTW = cnt_width(256);

  // Encodes up to 16 slave indices; callers slice off the lines they own.
  function automatic logic [15:0] psel_onehot(input logic [3:0] idx);
    logic [15:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/apb_rsp_mux.sv
// Combinational NSLV:1 select of the per-slave APB return signals.
module apb_rsp_mux #(
  parameter int unsigned NSLV = 4,
  parameter int unsigned SELW = 2
) (
  input  logic [SELW-1:0]      i_idx,
  input  logic [NSLV*32-1:0]   i_prdata,
  input  logic [NSLV-1:0]      i_pready,
  input  logic [NSLV-1:0]      i_pslverr,
  output logic [31:0]          o_rdata,
  output logic                 o_ready,
  output logic                 o_slverr
);

  // An out-of-range index selects nothing and returns all zeros.
  always_comb begin
    o_rdata  = '0;
    o_ready  = 1'b0;
    o_slverr = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      if (i_idx == SELW'(i)) begin
        o_rdata  = i_prdata[32*i +: 32];
        o_ready  = i_pready[i];
        o_slverr = i_pslverr[i];
      end
    end
  end

endmodule

// File: rtl/apb_master.sv
// APB3 initiator: single read/write commands in, one SETUP/ACCESS transfer and one response out.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned NSLV    = 4,
  parameter int unsigned DEC_LSB = 12,
  parameter int unsigned TIMEOUT = 256
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [31:0]          cmd_addr,
  input  logic [31:0]          cmd_wdata,
  output logic                 rsp_valid,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic [NSLV-1:0]      PSEL,
  output logic                 PENABLE,
  output logic                 PWRITE,
  output logic [31:0]          PADDR,
  output logic [31:0]          PWDATA,
  input  logic [NSLV*32-1:0]   PRDATA,
  input  logic [NSLV-1:0]      PREADY,
  input  logic [NSLV-1:0]      PSLVERR
);

  localparam int unsigned SEL_W = sel_width(NSLV);
  localparam int unsigned CNT_W = cnt_width(TIMEOUT);

  apb_state_e       r_state;
  apb_state_e       w_state_nxt;
  logic [SEL_W-1:0] r_idx;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pwrite;
  logic [31:0]      r_paddr;
  logic [31:0]      r_pwdata;
  logic             r_rsp_valid;
  logic             r_rsp_err;
  logic [31:0]      r_rsp_rdata;

  logic [SEL_W-1:0] w_idx;
  logic             w_idx_ok;
  logic             w_hs;
  logic             w_timeout;
  logic [31:0]      w_rdata;
  logic             w_ready;
  logic             w_slverr;
  logic [15:0]      w_sel_all;
  logic             w_unused_sel;

  assign w_idx    = cmd_addr[DEC_LSB +: SEL_W];
  assign w_idx_ok = (32'(w_idx) < NSLV);
  assign w_hs     = cmd_valid & cmd_ready;

  // Abort on the edge that would bring the wait count up to TIMEOUT.
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

  apb_rsp_mux #(
    .NSLV (NSLV),
    .SELW (SEL_W)
  ) u_rsp_mux (
    .i_idx     (r_idx),
    .i_prdata  (PRDATA),
    .i_pready  (PREADY),
    .i_pslverr (PSLVERR),
    .o_rdata   (w_rdata),
    .o_ready   (w_ready),
    .o_slverr  (w_slverr)
  );

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_hs) begin
          w_state_nxt = w_idx_ok ? StSetup : StDecerr;
        end
      end
      StSetup:  w_state_nxt = StAccess;
      StAccess: begin
        if (w_ready || w_timeout) begin
          w_state_nxt = StIdle;
        end
      end
      StDecerr: w_state_nxt = StIdle;
      default:  w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_idx       <= '0;
      r_cnt       <= '0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      if (w_hs) begin
        r_pwrite <= cmd_write;
        r_paddr  <= cmd_addr;
        r_pwdata <= cmd_wdata;
        r_idx    <= w_idx;
      end
      if (w_state_nxt == StSetup) begin
        r_cnt <= '0;
      end else if (r_state == StAccess && !w_ready && r_cnt != '1) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == StAccess) begin
        if (w_ready) begin
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= w_slverr;
          r_rsp_rdata <= (!r_pwrite && !w_slverr) ? w_rdata : '0;
        end else if (w_timeout) begin
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b1;
        end
      end else if (r_state == StDecerr) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err   <= 1'b1;
      end
    end
  end

  // Selects derive from the state register so reset drops them without waiting for a clock.
  assign w_sel_all    = psel_onehot(4'(r_idx));
  assign w_unused_sel = ^w_sel_all;
  assign PSEL         = (r_state == StSetup || r_state == StAccess) ? w_sel_all[NSLV-1:0] : '0;
  assign PENABLE      = (r_state == StAccess);
  assign PWRITE       = r_pwrite;
  assign PADDR        = r_paddr;
  assign PWDATA       = r_pwdata;
  assign cmd_ready    = (r_state == StIdle) & ~PRESET;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_err      = r_rsp_err;
  assign rsp_rdata    = r_rsp_rdata;

endmodule
